// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake and a one-entry skid buffer.
// Define PIPE_SKID_REG_STATS_EN to add the saturating stall_cnt output.
module pipe_skid_reg #(
    parameter int              WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int              CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_SKID_REG_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_fire;
    logic             out_fire;

    if (WIDTH < 1 || CNT_W < 1) begin : g_param_check
        $error("pipe_skid_reg: WIDTH and CNT_W must be at least 1");
    end

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (in_fire) state_nxt = ONE;
                ONE: begin
                    if (in_fire && !out_fire) begin
                        state_nxt = FULL;
                    end else if (!in_fire && out_fire) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL:    if (out_fire) state_nxt = ONE;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Handshake outputs depend only on the state register, so out_ready never reaches in_ready.
    always_comb begin
        in_ready  = (state != FULL);
        out_valid = (state != EMPTY);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            main_q <= RST_VAL;
            skid_q <= RST_VAL;
        end else begin
            case (state)
                EMPTY: if (in_fire) main_q <= in_data;
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data;
                    end else if (in_fire) begin
                        skid_q <= in_data;
                    end
                end
                FULL:    if (out_fire) main_q <= skid_q;
                default: ;
            endcase
        end
    end

    assign out_data = main_q;

`ifdef PIPE_SKID_REG_STATS_EN
    // Only rst clears the counter; flush leaves the statistic intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
